fpcvt_pipe: RTL and testbench

FPCVT_PIPE -- requirements
Module: fpcvt_pipe

---
 rtl/fpcvt_pkg.sv | 17 +
 rtl/fpcvt_lzd.sv | 19 +
 rtl/fpcvt_pipe.sv | 145 ++++++++++++++
 tb/tb_fpcvt_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fpcvt_pkg.sv
// Shared defaults and stage-payload record for the fixed-to-float converter.
package fpcvt_pkg;

    localparam int IN_W_DEF  = 13;
    localparam int EXP_W_DEF = 3;
    localparam int MAN_W_DEF = 5;

    // Normalised payload handed from S2 to S3 (default widths).
    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] e;
        logic [MAN_W_DEF-1:0] f;
        logic                 r;
        logic                 clamp;
    } fpcvt_pay_t;

endpackage

// File: rtl/fpcvt_lzd.sv
// Combinational leading-one detector: p is the index of the highest set bit.
module fpcvt_lzd #(
    parameter  int W  = 12,
    localparam int PW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  a,
    output logic [PW-1:0] p,
    output logic          zero
);

    always_comb begin
        p = '0;
        for (int i = 0; i < W; i++)
            if (a[i]) p = PW'(i);
    end

    assign zero = ~|a;

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage two's-complement to sign/exponent/significand converter.
// Define FPCVT_PIPE_ROUND_EN to round-half-up in S3; otherwise S3 truncates.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             S,
    output logic [EXP_W-1:0] E,
    output logic [MAN_W-1:0] F,
    output logic             sat
);

    localparam int MW = IN_W - 1;
    localparam int PW = (MW > 1) ? $clog2(MW) : 1;
    localparam logic [MAN_W-1:0] F_ONES = '1;
    localparam logic [MAN_W-1:0] F_MSB  = MAN_W'(1) << (MAN_W - 1);
    localparam logic [EXP_W-1:0] E_MAX  = '1;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        logic             r;
        logic             clamp;
    } pay_t;

    logic [3:1] vld_pipe;
    logic [3:1] adv;

    // A stage may load whenever it is empty or its successor is moving.
    assign adv[3]    = ~vld_pipe[3] | out_ready;
    assign adv[2]    = ~vld_pipe[2] | adv[3];
    assign adv[1]    = ~vld_pipe[1] | adv[2];
    assign in_ready  = adv[1];
    assign out_valid = vld_pipe[3];

    // S1: sign/magnitude; the most negative input has no positive twin, so clamp.
    logic          s1_clamp_d;
    logic [MW-1:0] s1_mag_d;
    logic [MW-1:0] neg_m;
    logic          s1_sign;
    logic          s1_clamp;
    logic [MW-1:0] s1_m;

    assign neg_m      = ~D[MW-1:0] + MW'(1);
    assign s1_clamp_d = D[IN_W-1] & ~|D[MW-1:0];
    assign s1_mag_d   = s1_clamp_d ? '1 : (D[IN_W-1] ? neg_m : D[MW-1:0]);

    // S2: normalise so F holds the MAN_W bits below and including the leading one.
    logic [PW-1:0] lz_p;
    logic          lz_zero;
    pay_t          s2_d;
    pay_t          s2_q;
    int            sh;

    fpcvt_lzd #(.W(MW)) u_lzd (
        .a    (s1_m),
        .p    (lz_p),
        .zero (lz_zero)
    );

    always_comb begin
        sh         = 0;
        s2_d.sign  = s1_sign;
        s2_d.clamp = s1_clamp;
        s2_d.e     = '0;
        s2_d.f     = MAN_W'(s1_m);
        s2_d.r     = 1'b0;
        if (!lz_zero && int'(lz_p) >= MAN_W) begin
            sh     = int'(lz_p) - MAN_W + 1;
            s2_d.e = EXP_W'(sh);
            s2_d.f = MAN_W'(s1_m >> sh);
            s2_d.r = s1_m[PW'(sh - 1)];
        end
    end

    // S3: optional rounding; a carry out of F bumps E, or saturates at E_MAX.
    logic [EXP_W-1:0] s3_e;
    logic [MAN_W-1:0] s3_f;
    logic             s3_sat;

    always_comb begin
        s3_e   = s2_q.e;
        s3_f   = s2_q.f;
        s3_sat = s2_q.clamp;
`ifdef FPCVT_PIPE_ROUND_EN
        if (s2_q.r) begin
            if (s2_q.f != F_ONES) begin
                s3_f = s2_q.f + MAN_W'(1);
            end else if (s2_q.e != E_MAX) begin
                s3_e = s2_q.e + EXP_W'(1);
                s3_f = F_MSB;
            end else begin
                s3_sat = 1'b1;
            end
        end
`endif
    end

`ifndef FPCVT_PIPE_ROUND_EN
    logic unused_r;
    assign unused_r = s2_q.r;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_sign  <= 1'b0;
            s1_clamp <= 1'b0;
            s1_m     <= '0;
            s2_q     <= '0;
            S        <= 1'b0;
            E        <= '0;
            F        <= '0;
            sat      <= 1'b0;
        end else begin
            if (adv[1]) vld_pipe[1] <= in_valid;
            if (adv[2]) vld_pipe[2] <= vld_pipe[1];
            if (adv[3]) vld_pipe[3] <= vld_pipe[2];
            if (adv[1] && in_valid) begin
                s1_sign  <= D[IN_W-1];
                s1_clamp <= s1_clamp_d;
                s1_m     <= s1_mag_d;
            end
            if (adv[2] && vld_pipe[1]) s2_q <= s2_d;
            if (adv[3] && vld_pipe[2]) begin
                S   <= s2_q.sign;
                E   <= s3_e;
                F   <= s3_f;
                sat <= s3_sat;
            end
        end
    end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Randomised and directed bench for fpcvt_pipe against an arithmetic reference model.
module tb_fpcvt_pipe;

    localparam int IN_W  = 13;
    localparam int EXP_W = 3;
    localparam int MAN_W = 5;
    localparam int RW    = EXP_W + MAN_W + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  D;
    logic             out_valid;
    logic             out_ready;
    logic             S;
    logic [EXP_W-1:0] E;
    logic [MAN_W-1:0] F;
    logic             sat;

    int               n_vec = 0;
    int               n_err = 0;
    logic [RW-1:0]    exp_q[$];

    always #5 clk = ~clk;

    fpcvt_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .sat       (sat)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: value = F * 2^E with the smallest E that fits M, then round-half-up.
    function automatic logic [RW-1:0] model(input logic [IN_W-1:0] d);
        longint v, m, f;
        int     e;
        logic   s, clamp, st;
        v     = longint'($signed(d));
        s     = d[IN_W-1];
        clamp = (v == -(longint'(1) << (IN_W - 1)));
        m     = clamp ? (longint'(1) << (IN_W - 1)) - 1 : ((v < 0) ? -v : v);
        e     = 0;
        while (m >= (longint'(1) << (MAN_W + e))) e++;
        f  = m >> e;
        st = clamp;
`ifdef FPCVT_PIPE_ROUND_EN
        if (e > 0 && ((m >> (e - 1)) & 1) != 0) begin
            f++;
            if (f == (longint'(1) << MAN_W)) begin
                if (e < (1 << EXP_W) - 1) begin
                    e++;
                    f = longint'(1) << (MAN_W - 1);
                end else begin
                    f  = (longint'(1) << MAN_W) - 1;
                    st = 1'b1;
                end
            end
        end
`endif
        return {s, EXP_W'(e), MAN_W'(f), st};
    endfunction

    function automatic logic [RW-1:0] obs();
        return {S, E, F, sat};
    endfunction

    // One cycle: drive at negedge, settle, score the output and input transfers.
    task automatic tick(input logic iv, input logic [IN_W-1:0] d, input logic ordy, output logic acc);
        @(negedge clk);
        in_valid  = iv;
        D         = d;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
            else                   chk("result", 64'(obs()), 64'(exp_q.pop_front()));
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(d));
    endtask

    task automatic direct(input string tag, input logic [IN_W-1:0] d, input logic [RW-1:0] want);
        @(negedge clk);
        in_valid  = 1'b1;
        D         = d;
        out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 chk({tag, "_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        #1 chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk(tag, 64'(obs()), 64'(want));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [IN_W-1:0] samp[5];
        logic [RW-1:0]   held;
        logic            acc, ir_seen;
        int              idx, acc_cnt;
        logic [IN_W-1:0] d;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; D = '0;
        repeat (2) @(negedge clk);
        #1 chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", 64'(obs()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

        direct("d422",  13'd422,       {1'b0, 3'd4, 5'b11010, 1'b0});
        direct("dm422", IN_W'(-422),   {1'b1, 3'd4, 5'b11010, 1'b0});
`ifdef FPCVT_PIPE_ROUND_EN
        direct("d63",   13'd63,        {1'b0, 3'd2, 5'b10000, 1'b0});
`else
        direct("d63",   13'd63,        {1'b0, 3'd1, 5'b11111, 1'b0});
`endif
        direct("dmin",  13'h1000,      {1'b1, 3'd7, 5'b11111, 1'b1});
        direct("dzero", 13'd0,         {1'b0, 3'd0, 5'b00000, 1'b0});
        direct("d31",   13'd31,        {1'b0, 3'd0, 5'b11111, 1'b0});
        @(negedge clk);

        // Back-pressure: five samples offered against a stalled consumer.
        samp[0] = 13'd100; samp[1] = IN_W'(-7); samp[2] = 13'd4095;
        samp[3] = 13'd1;   samp[4] = IN_W'(-3000);
        idx = 0; held = '0; ir_seen = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick(1'b1, samp[idx], 1'b0, acc);
            if (acc) idx++;
            if (c == 3) held = obs();
            if (c == 5) ir_seen = in_ready;
        end
        chk("stall_accepted", 64'(idx), 64'd3);
        chk("stall_in_ready", 64'(ir_seen), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_stable", 64'(obs()), 64'(held));
        for (int c = 0; c < 40 && !(idx == 5 && exp_q.size() == 0); c++) begin
            tick(idx < 5, samp[idx % 5], 1'b1, acc);
            if (acc) idx++;
        end
        chk("stall_all_accepted", 64'(idx), 64'd5);
        chk("stall_drained", 64'(exp_q.size()), 64'd0);

        // Random traffic on both ports.
        acc_cnt = 0;
        for (int c = 0; c < 60000 && acc_cnt < 10000; c++) begin
            case ($urandom_range(7))
                0:       d = '0;
                1:       d = 13'h1000;
                2:       d = IN_W'($urandom_range(127)) - IN_W'(64);
                3:       d = 13'h0fff;
                default: d = IN_W'($urandom);
            endcase
            tick($urandom_range(9) < 7, d, $urandom_range(9) < 6, acc);
            if (acc) acc_cnt++;
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick(1'b0, '0, 1'b1, acc);
        chk("rand_accepted", 64'(acc_cnt), 64'd10000);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        // Reset with every stage full: nothing in flight may surface afterwards.
        for (int c = 0; c < 4; c++) tick(1'b1, IN_W'($urandom), 1'b0, acc);
        chk("full_before_rst", 64'(out_valid), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1 chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_outputs", 64'(obs()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 6; c++) tick(1'b0, '0, 1'b1, acc);
        chk("post_rst_quiet", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
